reg_xfer_seq: RTL and testbench
===============================

# reg_xfer_seq

Register-transfer sequencer that owns the enable/strobe lines of the register bank. It accepts one transfer command per handshake, reads operands through the two tri-state read buses (A and B), and writes results back over the shared write-data bus using each register's `s` strobe. It sits directly upstream of the `Register` instances and drives their `en_a`, `en_b`, `s` and `d` inputs. The microcode/decoder drives it from above.

## Interface
- `WIDTH`, default 32: register and bus width.
- `NREGS`, default 16: number of registers; must be a power of two; `AW = $clog2(NREGS)`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command (IDLE only).
- `cmd_op`  in  2  operation: 0 MOVE, 1 EXG, 2 CLR, 3 SWAP.
- `cmd_src`  in  AW  source register index (MOVE, EXG).
- `cmd_dst`  in  AW  destination register index (all ops).
- `en_a`  out  NREGS  one-hot (or zero) A-bus output enables.
- `en_b`  out  NREGS  one-hot (or zero) B-bus enables.
- `s`  out  NREGS  write strobes; `s[i]` is only ever high together with `en_b[i]`.
- `bus_a`  in  WIDTH  resolved A bus.
- `bus_b`  in  WIDTH  resolved B bus.
- `d`  out  WIDTH  write data, common to all registers.
- `done`  out  1  one-cycle pulse: command completed.

## Operation
- **States:** IDLE, READ, WR1, WR2.
- **Accept:** on an edge with `cmd_valid & cmd_ready`, latch op, src and dst.
  - MOVE, EXG, SWAP: go to READ.
  - CLR: go to WR1.
- **READ:**
  - `en_a[src]=1`, except SWAP, which uses `en_a[dst]=1`.
  - EXG only: also `en_b[dst]=1`, `s=0`.
  - At the end of the cycle, capture `bus_a` into `tmp_a`; EXG also captures `bus_b` into `tmp_b`.
  - Next state: WR1.
- **WR1:** `en_b[dst]=1`, `s[dst]=1`. The value of `d` depends on op:
  - MOVE: `tmp_a`.
  - EXG: `tmp_a`.
  - CLR: 0.
  - SWAP: `{tmp_a[WIDTH/2-1:0], tmp_a[WIDTH-1:WIDTH/2]}`.
  - Next state: WR2 for EXG, else IDLE.
- **WR2 (EXG only):** `en_b[src]=1`, `s[src]=1`, `d=tmp_b`. Next state: IDLE.
- **`done`:** registered; high for exactly the one cycle after the last write state. That cycle is IDLE with `cmd_ready=1`, so back-to-back commands are allowed.
- **Outputs decoded from state:**
  - At most one bit of `en_a` is high at any time; the same holds for `en_b` and for `s`.
  - In IDLE, all enables and strobes are 0 and `d=0`.
- **EXG with src==dst:** executes normally (3 cycles); the register keeps its value.
- **Commands while busy:** `cmd_ready=0`, so they are not accepted; inputs are ignored until IDLE.

## Timing
- **Reset values:** state IDLE; `cmd_ready=1`, `en_a=en_b=s=0`, `d=0`, `done=0`, `tmp_a=tmp_b=0`.
- **Latency from accept edge to `done` high:**
  - MOVE and SWAP: 3 cycles (READ, WR1, done).
  - EXG: 4 cycles.
  - CLR: 2 cycles.
- **Throughput:** one command per (latency) cycles; the next command can be accepted on the edge that ends the `done` cycle.
- **Reset mid-operation:** the cycle in which `reset` is high still shows the current state's strobes. From the next cycle, all outputs are at their reset values, and the partial transfer is abandoned with no `done`. Reset has priority over a simultaneous accept.
- **Operand capture:** `bus_a`/`bus_b` must be stable (non-Z) by the end of the READ cycle. Captured values are unaffected by later bus activity.

## Test plan
1. **Reset, then MOVE:** after reset, R3=0xDEADBEEF; MOVE src=3 dst=7.
   - READ cycle: `en_a=16'h0008`.
   - WR1 cycle: `en_b=s=16'h0080`, `d=0xDEADBEEF`.
   - `done` 3 cycles after accept; R7=0xDEADBEEF.
2. **EXG:** R1=0x11111111, R2=0x22222222; EXG src=1 dst=2.
   - READ cycle: `en_a[1]` and `en_b[2]` high.
   - Result: R2=0x11111111, R1=0x22222222.
   - `done` at cycle 4 after accept; `s` never has two bits set.
3. **CLR then SWAP back-to-back:** R5=0x12345678; CLR dst=4 accepted in the same cycle as `done` from the previous command, then SWAP dst=5.
   - Result: R4=0, R5=0x56781234.
   - No idle gap beyond the `done` cycle.
4. **Busy rejection:** hold `cmd_valid=1` with a second MOVE during an EXG.
   - `cmd_ready` stays 0 until the EXG's `done`.
   - The second MOVE is accepted exactly once.
5. **Reset in WR1 of MOVE:** assert `reset` for one cycle during WR1.
   - Next cycle: all enables 0, `done=0`, `cmd_ready=1`.
   - A subsequent MOVE completes normally.
6. **EXG with src==dst=9:** R9=0xA5A5A5A5.
   - After `done` (4 cycles), R9 is still 0xA5A5A5A5.

Source files
------------

// File: rtl/reg_xfer_seq_if.sv
// Command handshake plus register-bank control/data lines of the transfer sequencer.
// The slave modport is the sequencer; the master side is the decoder together with the bank.
`timescale 1ns/1ps
interface reg_xfer_seq_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_src;
  logic [AW-1:0]    cmd_dst;
  logic [NREGS-1:0] en_a;
  logic [NREGS-1:0] en_b;
  logic [NREGS-1:0] s;
  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_b;
  logic [WIDTH-1:0] d;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, bus_a, bus_b,
    input  cmd_ready, en_a, en_b, s, d, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, bus_a, bus_b,
    output cmd_ready, en_a, en_b, s, d, done
  );
endinterface

// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer: reads operands over the A/B buses, then writes results
// back through the shared write-data bus with per-register strobes (MOVE/EXG/CLR/SWAP).
`timescale 1ns/1ps
module reg_xfer_seq #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic          clk,
  input  logic          reset,
  reg_xfer_seq_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WR1, ST_WR2} state_e;
  typedef enum logic [1:0] {OP_MOVE = 2'd0, OP_EXG = 2'd1, OP_CLR = 2'd2, OP_SWAP = 2'd3} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    src_q, src_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] tmp_a_q, tmp_a_d;
  logic [WIDTH-1:0] tmp_b_q, tmp_b_d;
  logic             done_q, done_d;

  logic [NREGS-1:0] en_a_c, en_b_c, s_c;
  logic [WIDTH-1:0] d_c;

  function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] idx);
    return NREGS'(1) << idx;
  endfunction

  // Bus enables, strobes and write data are decoded purely from the current state,
  // so a reset cycle still shows the strobes of the state it interrupts.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    tmp_a_d = tmp_a_q;
    tmp_b_d = tmp_b_q;
    done_d  = 1'b0;
    en_a_c  = '0;
    en_b_c  = '0;
    s_c     = '0;
    d_c     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = op_e'(bus.cmd_op);
          src_d   = bus.cmd_src;
          dst_d   = bus.cmd_dst;
          state_d = (op_e'(bus.cmd_op) == OP_CLR) ? ST_WR1 : ST_READ;
        end
      end
      ST_READ: begin
        en_a_c  = onehot((op_q == OP_SWAP) ? dst_q : src_q);
        tmp_a_d = bus.bus_a;
        if (op_q == OP_EXG) begin
          en_b_c  = onehot(dst_q);
          tmp_b_d = bus.bus_b;
        end
        state_d = ST_WR1;
      end
      ST_WR1: begin
        en_b_c = onehot(dst_q);
        s_c    = onehot(dst_q);
        unique case (op_q)
          OP_MOVE, OP_EXG: d_c = tmp_a_q;
          OP_CLR:          d_c = '0;
          OP_SWAP:         d_c = {tmp_a_q[WIDTH/2-1:0], tmp_a_q[WIDTH-1:WIDTH/2]};
        endcase
        if (op_q == OP_EXG) begin
          state_d = ST_WR2;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_WR2: begin
        en_b_c  = onehot(src_q);
        s_c     = onehot(src_q);
        d_c     = tmp_b_q;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  // NOTE: synchronous reset clears the operand latches too, so tmp_a/tmp_b read zero after reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MOVE;
      src_q   <= '0;
      dst_q   <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
      done_q  <= done_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.en_a      = en_a_c;
  assign bus.en_b      = en_b_c;
  assign bus.s         = s_c;
  assign bus.d         = d_c;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_reg_xfer_seq.sv
// Self-checking bench for reg_xfer_seq: a behavioural register bank on the buses, a
// command-level reference model of register contents, and per-cycle expected bus activity.
`timescale 1ns/1ps
module tb_reg_xfer_seq;
  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int AW    = $clog2(NREGS);

  typedef enum logic [1:0] {MOVE = 2'd0, EXG = 2'd1, CLR = 2'd2, SWAP = 2'd3} op_t;

  typedef struct packed {
    logic             ready;
    logic             done;
    logic [NREGS-1:0] en_a;
    logic [NREGS-1:0] en_b;
    logic [NREGS-1:0] s;
    logic [WIDTH-1:0] d;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  reg_xfer_seq_if #(.WIDTH(WIDTH), .NREGS(NREGS)) ifc ();
  reg_xfer_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (.clk(clk), .reset(reset), .bus(ifc));

  always #5 clk = ~clk;

  // Behavioural register bank: tri-state read buses and strobed writes.
  logic [WIDTH-1:0] bank      [NREGS];
  logic [WIDTH-1:0] init_bank [NREGS];
  logic [WIDTH-1:0] model     [NREGS];
  logic             load_bank = 1'b0;

  always @(posedge clk) begin
    if (load_bank) bank <= init_bank;
    else for (int i = 0; i < NREGS; i++) if (ifc.s[i]) bank[i] <= ifc.d;
  end

  always_comb begin
    ifc.bus_a = 'z;
    ifc.bus_b = 'z;
    for (int i = 0; i < NREGS; i++) begin
      if (ifc.en_a[i]) ifc.bus_a = bank[i];
      if (ifc.en_b[i]) ifc.bus_b = bank[i];
    end
  end

  function automatic obs_t sample();
    return {ifc.cmd_ready, ifc.done, ifc.en_a, ifc.en_b, ifc.s, ifc.d};
  endfunction

  function automatic logic [NREGS-1:0] oh(input int i);
    logic [NREGS-1:0] r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] half_swap(input logic [WIDTH-1:0] x);
    return {x[WIDTH/2-1:0], x[WIDTH-1:WIDTH/2]};
  endfunction

  function automatic obs_t idle_obs(input logic done);
    obs_t o = '0;
    o.ready = 1'b1;
    o.done  = done;
    return o;
  endfunction

  task automatic check_obs(input string tag, input obs_t o, input obs_t e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic check_word(input string tag, input logic [WIDTH-1:0] o, input logic [WIDTH-1:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NREGS; i++) check_word($sformatf("%s R%0d", tag, i), bank[i], model[i]);
  endtask

  // Issue one command (entered and left at 1 ns after an edge, in an IDLE cycle) and
  // check every cycle up to and including the done cycle, then the bank contents.
  task automatic run_cmd(input op_t op, input int src, input int dst, input string tag);
    obs_t             exp_q[$];
    obs_t             e;
    logic [WIDTH-1:0] a, b;
    a = model[src];
    b = model[dst];
    case (op)
      MOVE: begin
        e = '0; e.en_a = oh(src); exp_q.push_back(e);
        e = '0; e.en_b = oh(dst); e.s = oh(dst); e.d = a; exp_q.push_back(e);
        model[dst] = a;
      end
      EXG: begin
        e = '0; e.en_a = oh(src); e.en_b = oh(dst); exp_q.push_back(e);
        e = '0; e.en_b = oh(dst); e.s = oh(dst); e.d = a; exp_q.push_back(e);
        e = '0; e.en_b = oh(src); e.s = oh(src); e.d = b; exp_q.push_back(e);
        model[dst] = a;
        model[src] = b;
      end
      CLR: begin
        e = '0; e.en_b = oh(dst); e.s = oh(dst); e.d = '0; exp_q.push_back(e);
        model[dst] = '0;
      end
      SWAP: begin
        e = '0; e.en_a = oh(dst); exp_q.push_back(e);
        e = '0; e.en_b = oh(dst); e.s = oh(dst); e.d = half_swap(b); exp_q.push_back(e);
        model[dst] = half_swap(b);
      end
    endcase
    exp_q.push_back(idle_obs(1'b1));

    check_word({tag, " ready@issue"}, {31'd0, ifc.cmd_ready}, 32'd1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_src   = AW'(src);
    ifc.cmd_dst   = AW'(dst);
    tick();
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'($urandom);
    ifc.cmd_src   = AW'($urandom);
    ifc.cmd_dst   = AW'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      check_obs($sformatf("%s c%0d", tag, k + 1), sample(), exp_q[k]);
      if (k < exp_q.size() - 1) tick();
    end
    check_bank(tag);
  endtask

  initial begin
    obs_t e;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = '0;
    ifc.cmd_src   = '0;
    ifc.cmd_dst   = '0;

    tick();
    tick();
    check_obs("reset state", sample(), idle_obs(1'b0));

    for (int i = 0; i < NREGS; i++) init_bank[i] = $urandom;
    init_bank[1] = 32'h1111_1111;
    init_bank[2] = 32'h2222_2222;
    init_bank[3] = 32'hDEAD_BEEF;
    init_bank[5] = 32'h1234_5678;
    init_bank[9] = 32'hA5A5_A5A5;
    for (int i = 0; i < NREGS; i++) model[i] = init_bank[i];
    load_bank = 1'b1;
    tick();
    load_bank = 1'b0;
    reset     = 1'b0;

    run_cmd(MOVE, 3, 7, "t1 move");
    check_word("t1 R7", bank[7], 32'hDEAD_BEEF);
    tick();

    run_cmd(EXG, 1, 2, "t2 exg");
    check_word("t2 R1", bank[1], 32'h2222_2222);
    check_word("t2 R2", bank[2], 32'h1111_1111);

    // Back-to-back: CLR accepted on the edge ending the EXG's done cycle.
    run_cmd(CLR, 0, 4, "t3 clr");
    run_cmd(SWAP, 0, 5, "t3 swap");
    check_word("t3 R4", bank[4], 32'h0000_0000);
    check_word("t3 R5", bank[5], 32'h5678_1234);
    tick();

    // Busy rejection: a MOVE held valid throughout an EXG.
    begin
      logic [WIDTH-1:0] tmp;
      tmp = model[10]; model[10] = model[11]; model[11] = tmp;
    end
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = EXG;
    ifc.cmd_src   = AW'(10);
    ifc.cmd_dst   = AW'(11);
    tick();
    ifc.cmd_op  = MOVE;
    ifc.cmd_src = AW'(12);
    ifc.cmd_dst = AW'(13);
    for (int k = 1; k <= 4; k++) begin
      check_word($sformatf("t4 busy ready/done c%0d", k), {30'd0, ifc.cmd_ready, ifc.done},
                 (k == 4) ? 32'd3 : 32'd0);
      if (k < 4) tick();
    end
    run_cmd(MOVE, 12, 13, "t4 move");
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_obs($sformatf("t4 single accept c%0d", k), sample(), idle_obs(1'b0));
    end

    // Reset during WR1 of a MOVE; the WR1 strobe is still shown, so that write lands.
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = MOVE;
    ifc.cmd_src   = AW'(6);
    ifc.cmd_dst   = AW'(8);
    tick();
    ifc.cmd_valid = 1'b0;
    tick();
    e = '0; e.en_b = oh(8); e.s = oh(8); e.d = model[6];
    check_obs("t5 wr1", sample(), e);
    model[8] = model[6];
    reset = 1'b1;
    tick();
    check_obs("t5 after reset", sample(), idle_obs(1'b0));
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = CLR;
    ifc.cmd_dst   = AW'(0);
    tick();
    reset         = 1'b0;
    ifc.cmd_valid = 1'b0;
    check_obs("t5 reset priority", sample(), idle_obs(1'b0));
    check_bank("t5 bank");
    run_cmd(MOVE, 3, 14, "t5 move");
    tick();

    run_cmd(EXG, 9, 9, "t6 exg self");
    check_word("t6 R9", bank[9], 32'hA5A5_A5A5);

    // Randomized command stream with occasional idle gaps.
    for (int n = 0; n < 24; n++) begin
      run_cmd(op_t'($urandom_range(0, 3)), $urandom_range(0, NREGS - 1),
              $urandom_range(0, NREGS - 1), $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) begin
        tick();
        check_obs($sformatf("rnd%0d gap", n), sample(), idle_obs(1'b0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
